// File: rtl/asap_pkg.sv
// Shared types for the ASAP datapath arbiter.
// FSM state encoding and ID width helper.
package asap_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        GO,
        WAIT,
        RESP
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/asap_arbiter_if.sv
// Requester, response and datapath buses of the arbiter.
// slave = arbiter side, master = system side.
interface asap_arbiter_if
    import asap_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);

    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;

    logic                  dp_go;
    logic [WIDTH-1:0]      dp_in0;
    logic [WIDTH-1:0]      dp_in1;
    logic                  dp_done;
    logic [WIDTH-1:0]      dp_result;

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready,
        output dp_go, dp_in0, dp_in1,
        input  dp_done, dp_result
    );

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready,
        input  dp_go, dp_in0, dp_in1,
        output dp_done, dp_result
    );

endinterface

// File: rtl/asap_rr_pick.sv
// Round-robin picker: first valid requester after last_grant.
// Purely combinational.
module asap_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  sel,
    output logic            any_valid
);

    logic [IDW-1:0] idx;

    // Scan from the farthest offset down so the nearest valid one wins.
    always_comb begin
        grant     = '0;
        sel       = '0;
        idx       = '0;
        any_valid = |req_valid;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(last_grant) + k) % NREQ);
            if (req_valid[idx]) begin
                sel = idx;
            end
        end
        grant[sel] = any_valid;
    end

endmodule

// File: rtl/asap_arbiter.sv
// Shares one ASAP datapath between NREQ requesters.
// Round-robin accept, go/done sequencing, watchdog abort.
module asap_arbiter
    import asap_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    asap_arbiter_if.slave  bus,
    output logic           busy
);

    localparam int IDW = id_width(NREQ);
    localparam int WDW = $clog2(TIMEOUT) + 1;

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   cur_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             err;
    logic [WDW-1:0]   wd;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   sel;
    logic             any_valid;

    asap_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid  (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .sel        (sel),
        .any_valid  (any_valid)
    );

    logic active;
    assign active = (state == GO) || (state == WAIT);

    // Ready is only offered while idle and out of reset.
    assign bus.req_ready = (rst_n && state == IDLE) ? grant : '0;

    assign bus.dp_go     = (state == GO);
    assign bus.dp_in0    = active ? op_a : '0;
    assign bus.dp_in1    = active ? op_b : '0;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = cur_id;
    assign bus.rsp_data  = result;
    assign bus.rsp_err   = err;
    assign busy          = (state != IDLE);

    // Control FSM with operand, result and watchdog registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            cur_id     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            err        <= 1'b0;
            wd         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a   <= bus.req_a[sel*WIDTH +: WIDTH];
                        op_b   <= bus.req_b[sel*WIDTH +: WIDTH];
                        cur_id <= sel;
                        state  <= GO;
                    end
                end
                GO: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wd <= wd + 1'b1;
                    if (bus.dp_done) begin
                        result <= bus.dp_result;
                        err    <= 1'b0;
                        state  <= RESP;
                    end else if (wd == WDW'(TIMEOUT - 1)) begin
                        result <= '0;
                        err    <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        last_grant <= cur_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
